// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous video RAM between the Z80
// CPU and the MC6847 renderer fetch port. Video has strict priority. The CPU
// request is synchronized into PIX_CLK, parked in PEND until the renderer
// leaves a free cycle, and the CPU is held off through CPU_WAIT_N until the
// access has completed.
//
// Optional feature macro: VRAM_SNOW_EN. When it is defined, the CPU takes the
// RAM on its first PEND cycle even if video is reading. The colliding video
// slot then returns the CPU byte, which reproduces VZ200 "snow".
//
// Ports:
//   PIX_CLK, RESET_N        clock; asynchronous active-low reset
//   CPU_CS, CPU_WR          CPU select/direction (asynchronous to PIX_CLK)
//   CPU_A, CPU_DO, CPU_DI   CPU address, write data, read data
//   CPU_WAIT_N              Z80 WAIT, combinational from raw CPU_CS
//   VID_RD, VID_A, VID_D    renderer read port (2-edge latency, pipelined)
//   RAM_A, RAM_D, RAM_WE    RAM address/data/write strobe (combinational mux)
//   RAM_Q                   RAM read data, valid one cycle after address
`timescale 1ns/1ps
module vram_arbiter #(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned DATA_W     = 8
) (
    input  logic              PIX_CLK,
    input  logic              RESET_N,
    input  logic              CPU_CS,
    input  logic              CPU_WR,
    input  logic [ADDR_W-1:0] CPU_A,
    input  logic [DATA_W-1:0] CPU_DO,
    output logic [DATA_W-1:0] CPU_DI,
    output logic              CPU_WAIT_N,
    input  logic              VID_RD,
    input  logic [ADDR_W-1:0] VID_A,
    output logic [DATA_W-1:0] VID_D,
    output logic [ADDR_W-1:0] RAM_A,
    output logic [DATA_W-1:0] RAM_D,
    output logic              RAM_WE,
    input  logic [DATA_W-1:0] RAM_Q
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("vram_arbiter: SYNC_STAGES must be 2 or 3");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] wr_sync;
    logic                   cs_s;
    logic                   wr_s;
    logic                   cs_s_d;
    logic                   cs_rise_c;

    logic [ADDR_W-1:0]      cpu_a_q;
    logic [DATA_W-1:0]      cpu_d_q;
    logic                   wr_q;
    logic                   done;
    logic                   vid_q;
    logic                   cpu_issue_c;
`ifdef VRAM_SNOW_EN
    logic                   snow_q;
`endif

    // Synchronizers for the asynchronous CPU select and direction.
    always_ff @(posedge PIX_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cs_sync <= '0;
            wr_sync <= '0;
            cs_s_d  <= 1'b0;
        end else begin
            cs_sync <= {cs_sync[SYNC_STAGES-2:0], CPU_CS};
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], CPU_WR};
            cs_s_d  <= cs_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign wr_s      = wr_sync[SYNC_STAGES-1];
    assign cs_rise_c = cs_s & ~cs_s_d;

    // State register.
    always_ff @(posedge PIX_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and CPU issue decision.
    always_comb begin
        state_nxt   = state;
        cpu_issue_c = 1'b0;
        case (state)
            IDLE: begin
                if (cs_rise_c) begin
                    state_nxt = PEND;
                end
            end
            PEND: begin
`ifdef VRAM_SNOW_EN
                // CPU pre-empts any video fetch in this slot.
                cpu_issue_c = 1'b1;
                state_nxt   = ACCESS;
`else
                // Video owns the RAM whenever it asks for it.
                if (!VID_RD) begin
                    cpu_issue_c = 1'b1;
                    state_nxt   = ACCESS;
                end
`endif
            end
            ACCESS: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (!cs_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // RAM port mux; reset forces IDLE, so a pending write strobe drops at once.
    always_comb begin
        RAM_A  = VID_A;
        RAM_D  = cpu_d_q;
        RAM_WE = 1'b0;
        if (cpu_issue_c) begin
            RAM_A  = cpu_a_q;
            RAM_WE = wr_q;
        end
    end

    // CPU request capture, read data return and completion flag.
    always_ff @(posedge PIX_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cpu_a_q <= '0;
            cpu_d_q <= '0;
            wr_q    <= 1'b0;
            CPU_DI  <= '0;
            done    <= 1'b0;
        end else begin
            if (state == IDLE && cs_rise_c) begin
                cpu_a_q <= CPU_A;
                cpu_d_q <= CPU_DO;
                wr_q    <= wr_s;
            end
            if (state == ACCESS) begin
                if (!wr_q) begin
                    CPU_DI <= RAM_Q;
                end
                done <= 1'b1;
            end
            if (state == HOLD && !cs_s) begin
                done <= 1'b0;
            end
        end
    end

    // Video return path: tag who owns this cycle's RAM read, capture next edge.
    always_ff @(posedge PIX_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vid_q <= 1'b0;
            VID_D <= '0;
`ifdef VRAM_SNOW_EN
            snow_q <= 1'b0;
`endif
        end else begin
            vid_q <= VID_RD & ~cpu_issue_c;
`ifdef VRAM_SNOW_EN
            snow_q <= VID_RD & cpu_issue_c;
`endif
            if (vid_q) begin
                VID_D <= RAM_Q;
            end
`ifdef VRAM_SNOW_EN
            // Collided slot shows the CPU byte: write data, or the CPU read result.
            else if (snow_q) begin
                VID_D <= wr_q ? cpu_d_q : RAM_Q;
            end
`endif
        end
    end

    // WAIT is taken from the raw select so the Z80 sees it in T2.
    assign CPU_WAIT_N = ~(CPU_CS & ~done);

endmodule

// File: tb/tb_vram_arbiter.sv
`timescale 1ns/1ps
module tb_vram_arbiter;

    localparam int AW = 13;
`ifdef VRAM_SNOW_EN
    localparam int CONT = 0;
`else
    localparam int CONT = 1;
`endif

    logic          PIX_CLK = 1'b0;
    logic          RESET_N;
    logic          CPU_CS;
    logic          CPU_WR;
    logic [AW-1:0] CPU_A;
    logic [7:0]    CPU_DO;
    logic [7:0]    CPU_DI;
    logic          CPU_WAIT_N;
    logic          VID_RD;
    logic [AW-1:0] VID_A;
    logic [7:0]    VID_D;
    logic [AW-1:0] RAM_A;
    logic [7:0]    RAM_D;
    logic          RAM_WE;
    logic [7:0]    RAM_Q;

    logic [7:0]    mem [0:8191];

    int n_cmp = 0;
    int n_err = 0;

    vram_arbiter dut (
        .PIX_CLK    (PIX_CLK),
        .RESET_N    (RESET_N),
        .CPU_CS     (CPU_CS),
        .CPU_WR     (CPU_WR),
        .CPU_A      (CPU_A),
        .CPU_DO     (CPU_DO),
        .CPU_DI     (CPU_DI),
        .CPU_WAIT_N (CPU_WAIT_N),
        .VID_RD     (VID_RD),
        .VID_A      (VID_A),
        .VID_D      (VID_D),
        .RAM_A      (RAM_A),
        .RAM_D      (RAM_D),
        .RAM_WE     (RAM_WE),
        .RAM_Q      (RAM_Q)
    );

    always #5 PIX_CLK = ~PIX_CLK;

    // Synchronous single-port RAM, read-before-write.
    always @(posedge PIX_CLK) begin
        if (RAM_WE) mem[RAM_A] <= RAM_D;
        RAM_Q <= mem[RAM_A];
    end

    function automatic logic [7:0] pattern(input logic [AW-1:0] a);
        return a[7:0] ^ {a[12:8], 3'b101};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge PIX_CLK);
        #1;
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] a;
        logic [7:0]    d;
        int            busy;
        logic [7:0]    exp_di;
        int            exp_wait;
    } vec_t;

    // One CPU transaction; video reads for 'busy' cycles starting at the PEND entry edge.
    task automatic run_txn(input vec_t v, input string tag);
        int            edges;
        int            we_cnt;
        logic [AW-1:0] we_a;
        logic [7:0]    we_d;
        bit            fin;
        edges = 0; we_cnt = 0; we_a = '0; we_d = '0; fin = 0;
        CPU_WR = v.wr; CPU_A = v.a; CPU_DO = v.d; VID_RD = 1'b0; CPU_CS = 1'b1;
        #1;
        check({tag, " wait_low"}, 32'(CPU_WAIT_N), 32'd0);
        while (!fin && edges < 100) begin
            tick();
            edges++;
            if (v.busy > 0 && edges == 3) begin
                VID_RD = 1'b1;
                VID_A  = 13'h0100;
            end
            if (edges == 3 + v.busy) VID_RD = 1'b0;
            #1;
            if (RAM_WE) begin
                we_cnt++;
                we_a = RAM_A;
                we_d = RAM_D;
            end
            if (CPU_WAIT_N) fin = 1;
        end
        check({tag, " wait_edges"}, 32'(edges), 32'(v.exp_wait));
        if (v.wr) begin
            check({tag, " we_count"}, 32'(we_cnt), 32'd1);
            check({tag, " we_addr"}, 32'(we_a), 32'(v.a));
            check({tag, " we_data"}, 32'(we_d), 32'(v.d));
        end else begin
            check({tag, " we_count"}, 32'(we_cnt), 32'd0);
            check({tag, " cpu_di"}, 32'(CPU_DI), 32'(v.exp_di));
        end
        CPU_CS = 1'b0;
        VID_RD = 1'b0;
        repeat (4) tick();
        check({tag, " wait_idle"}, 32'(CPU_WAIT_N), 32'd1);
    endtask

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            edges;
        int            bad;
        int            wait_edge;
        int            we_cnt;
        logic [AW-1:0] we_a;
        logic [7:0]    we_d;
        logic [7:0]    exp_v;

        for (int i = 0; i < 8192; i++) mem[i] = pattern(13'(i));

        vecs[0] = '{wr:1'b1, a:13'h0123, d:8'h5A, busy:0, exp_di:8'h00, exp_wait:5};
        vecs[1] = '{wr:1'b0, a:13'h0123, d:8'h00, busy:0, exp_di:8'h5A, exp_wait:5};
        vecs[2] = '{wr:1'b1, a:13'h0000, d:8'h11, busy:2, exp_di:8'h00, exp_wait:5 + CONT*2};
        vecs[3] = '{wr:1'b0, a:13'h0000, d:8'h00, busy:0, exp_di:8'h11, exp_wait:5};
        vecs[4] = '{wr:1'b1, a:13'h1FFF, d:8'hC3, busy:0, exp_di:8'h00, exp_wait:5};
        vecs[5] = '{wr:1'b0, a:13'h1FFF, d:8'h00, busy:3, exp_di:8'hC3, exp_wait:5 + CONT*3};
        vecs[6] = '{wr:1'b0, a:13'h0456, d:8'h00, busy:1, exp_di:8'h73, exp_wait:5 + CONT*1};

        // Reset state
        RESET_N = 1'b0; CPU_CS = 1'b0; CPU_WR = 1'b0; CPU_A = '0; CPU_DO = '0;
        VID_RD = 1'b0; VID_A = '0;
        #3;
        check("rst vid_d", 32'(VID_D), 32'h00);
        check("rst cpu_di", 32'(CPU_DI), 32'h00);
        check("rst ram_we", 32'(RAM_WE), 32'd0);
        check("rst wait_n", 32'(CPU_WAIT_N), 32'd1);
        CPU_CS = 1'b1;
        #1;
        check("rst wait_follows_cs", 32'(CPU_WAIT_N), 32'd0);
        CPU_CS = 1'b0;
        repeat (2) tick();
        RESET_N = 1'b1;
        repeat (2) tick();

        // Table-driven CPU transactions
        for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Video read-back of the CPU-written byte
        VID_RD = 1'b1; VID_A = 13'h0123;
        tick();
        VID_RD = 1'b0; VID_A = 13'h0000;
        tick();
        check("vid readback", 32'(VID_D), 32'h5A);
        tick();
        check("vid hold", 32'(VID_D), 32'h5A);

        // Contention: video reads 10 cycles starting at PEND entry
`ifdef VRAM_SNOW_EN
        CPU_WR = 1'b1; CPU_A = 13'h0200; CPU_DO = 8'h77;
`else
        CPU_WR = 1'b0; CPU_A = 13'h0123; CPU_DO = 8'h00;
`endif
        CPU_CS = 1'b1;
        edges = 0; bad = 0; wait_edge = 0;
        while (edges < 16) begin
            tick();
            edges++;
            if (edges >= 3 && edges <= 12) begin
                VID_RD = 1'b1;
                VID_A  = 13'h0100 + 13'(edges - 3);
            end else begin
                VID_RD = 1'b0;
            end
            #1;
`ifdef VRAM_SNOW_EN
            if (edges == 3) begin
                check("snow issue we", 32'(RAM_WE), 32'd1);
                check("snow issue addr", 32'(RAM_A), 32'h0200);
                check("snow issue data", 32'(RAM_D), 32'h77);
            end
            if (edges >= 4 && edges <= 12 && (RAM_A !== VID_A || RAM_WE !== 1'b0)) bad++;
`else
            if (edges >= 3 && edges <= 12 && (RAM_A !== VID_A || RAM_WE !== 1'b0)) bad++;
            if (edges == 13) check("cont issue addr", 32'(RAM_A), 32'h0123);
`endif
            if (edges >= 5 && edges <= 14) begin
                exp_v = pattern(13'h0100 + 13'(edges - 5));
`ifdef VRAM_SNOW_EN
                if (edges == 5) exp_v = 8'h77;
`endif
                check($sformatf("cont vid_d slot%0d", edges - 5), 32'(VID_D), 32'(exp_v));
            end
            if (CPU_WAIT_N && wait_edge == 0) wait_edge = edges;
        end
        check("cont video owns ram", 32'(bad), 32'd0);
        check("cont wait_edge", 32'(wait_edge), 32'(5 + CONT*10));
`ifndef VRAM_SNOW_EN
        check("cont cpu_di", 32'(CPU_DI), 32'h5A);
`endif
        CPU_CS = 1'b0;
        repeat (4) tick();

        // Abort: one-cycle CS pulse, write must still land
        CPU_WR = 1'b1; CPU_A = 13'h1FFF; CPU_DO = 8'hA5; CPU_CS = 1'b1;
        edges = 0; bad = 0; we_cnt = 0; we_a = '0; we_d = '0;
        while (edges < 16) begin
            tick();
            edges++;
            if (edges == 1) CPU_CS = 1'b0;
            if (edges >= 3 && edges <= 6) begin
                VID_RD = 1'b1;
                VID_A  = 13'h0040 + 13'(edges);
            end else begin
                VID_RD = 1'b0;
            end
            #1;
            if (RAM_WE) begin
                we_cnt++;
                we_a = RAM_A;
                we_d = RAM_D;
            end
            if (!CPU_WAIT_N) bad++;
        end
        check("abort we_count", 32'(we_cnt), 32'd1);
        check("abort we_addr", 32'(we_a), 32'h1FFF);
        check("abort we_data", 32'(we_d), 32'hA5);
        check("abort wait_n high", 32'(bad), 32'd0);
        run_txn('{wr:1'b0, a:13'h1FFF, d:8'h00, busy:0, exp_di:8'hA5, exp_wait:5}, "abort_rb");

        // Reset in the middle of a pending write
        CPU_WR = 1'b1; CPU_A = 13'h0300; CPU_DO = 8'hEE; VID_RD = 1'b0; CPU_CS = 1'b1;
        repeat (3) tick();
        RESET_N = 1'b0;
        #1;
        check("midrst ram_we", 32'(RAM_WE), 32'd0);
        check("midrst wait_n", 32'(CPU_WAIT_N), 32'd0);
        CPU_CS = 1'b0;
        repeat (3) tick();
        RESET_N = 1'b1;
        repeat (3) tick();
        run_txn('{wr:1'b0, a:13'h0300, d:8'h00, busy:0, exp_di:8'h1D, exp_wait:5}, "midrst_rb");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

- Shares the single-port synchronous video RAM between the Z80 CPU and the MC6847 VGA renderer's fetch port (`RD`/`DA`/`DD`).
- Sits directly upstream of the renderer, which sees a plain read port.
- The CPU side is synchronized, stalled via `CPU_WAIT_N`, and serviced in cycles the renderer leaves free.
- Optionally reproduces the VZ200 "snow" effect by letting the CPU pre-empt video fetches.

## Interface
Parameters:
- `ADDR_W`, default 13: VRAM address width (8 KB).
- `SYNC_STAGES`, default 2: synchronizer depth for `CPU_CS`/`CPU_WR`; legal values 2 or 3.

Ports:
- `PIX_CLK`  in  1: sole clock; the renderer runs on it.
- `RESET_N`  in  1: asynchronous, active-low reset.
- `CPU_CS`  in  1: CPU VRAM select, level, asynchronous to `PIX_CLK`.
- `CPU_WR`  in  1: 1 = write, 0 = read; stable while `CPU_CS`=1.
- `CPU_A`  in  ADDR_W: CPU address; stable while `CPU_CS`=1.
- `CPU_DO`  in  8: CPU write data.
- `CPU_DI`  out  8: read data returned to the CPU.
- `CPU_WAIT_N`  out  1: Z80 WAIT, active-low.
- `VID_RD`  in  1: renderer read request, one byte per asserted cycle.
- `VID_A`  in  ADDR_W: renderer address.
- `VID_D`  out  8: renderer read data.
- `RAM_A`  out  ADDR_W: RAM address.
- `RAM_D`  out  8: RAM write data.
- `RAM_WE`  out  1: RAM write strobe.
- `RAM_Q`  in  8: RAM read data, valid 1 cycle after the address.

## Operation
Inputs and synchronization:
- `CPU_CS` and `CPU_WR` pass through `SYNC_STAGES` flops, giving `cs_s`/`wr_s`.
- A rising edge of `cs_s` starts a transaction.
- `CPU_A`/`CPU_DO` are sampled into `cpu_a_q`/`cpu_d_q` on that edge; they are stable by then.

FSM states:
- `IDLE`: on `cs_s` rise, latch `cpu_a_q`, `cpu_d_q`, `wr_q` → `PEND`.
- `PEND`: if `VID_RD`=0, issue the CPU access this cycle → `ACCESS`; else stay.
- `ACCESS`: `RAM_Q` is valid. For a read, `CPU_DI`<=`RAM_Q`. Set `done` → `HOLD`.
- `HOLD`: wait for `cs_s`=0, then clear `done` → `IDLE`.

RAM mux (combinational):
- When the CPU access is issued: `RAM_A`=`cpu_a_q`, `RAM_WE`=`wr_q`, `RAM_D`=`cpu_d_q`.
- Otherwise: `RAM_A`=`VID_A`, `RAM_WE`=0.

Video path:
- A `vid_q` flag records whether this cycle's RAM read belongs to video.
- When `vid_q`=1, `VID_D`<=`RAM_Q` on the next edge.
- `VID_D` holds its value otherwise.

Wait generation:
- `CPU_WAIT_N` = ~(`CPU_CS` & ~`done`). It asserts combinationally from the raw select so the Z80 samples it in T2.

Boundary conditions:
- Video continuously busy (no `SNOW`): the CPU waits indefinitely. The renderer guarantees idle cycles during blanking.
- `CPU_CS` deasserted while in `PEND`: the access still completes and the FSM returns through `HOLD` to `IDLE`. Writes are never dropped.
- New `cs_s` rise while in `HOLD`: impossible, since `HOLD` exits only on `cs_s`=0.
- `RESET_N` low mid-transaction: FSM → `IDLE`. Any pending write is abandoned and `RAM_WE` drops immediately.

Reset values:
- `CPU_DI`=0, `VID_D`=0, `done`=0, `vid_q`=0, `RAM_WE`=0, `cpu_a_q`=0, `cpu_d_q`=0.
- `CPU_WAIT_N` follows `CPU_CS` (low while selected).

## Timing
Uncontended CPU access:
- `cs_s` rises `SYNC_STAGES` edges after `CPU_CS`.
- `PEND` follows 1 edge later.
- The RAM cycle is issued in `PEND`.
- `CPU_DI` and `done` update at the end of `ACCESS`.
- `CPU_WAIT_N` rises `SYNC_STAGES`+3 edges after `CPU_CS`; that is 5 with the default.

Video latency:
- `VID_RD` at edge n gives `VID_D` valid after edge n+2.
- One request per cycle is sustained, fully pipelined.

Contention:
- Each cycle of `VID_RD`=1 while in `PEND` adds exactly 1 cycle of wait.

## Configuration
`VRAM_SNOW_EN`:
- Defined:
  - The CPU never waits in `PEND`: it takes the RAM the cycle it enters `PEND`, even when `VID_RD`=1.
  - The colliding video read does not get RAM data. One cycle later `VID_D` gets `cpu_d_q` for a write and `RAM_Q` of the CPU address for a read.
  - This reproduces VZ200 snow; video latency is unchanged.
- Undefined: video has strict priority, as described above.

## Test plan
- Reset: drive `RESET_N`=0 with `CPU_CS`=0 → `VID_D`=0x00, `CPU_DI`=0x00, `RAM_WE`=0, `CPU_WAIT_N`=1.
- Uncontended write: `CPU_CS`=1, `CPU_WR`=1, A=0x0123, D=0x5A, `VID_RD`=0 → one `RAM_WE` pulse at 0x0123 with `RAM_D`=0x5A; `CPU_WAIT_N` rises 5 edges after `CS`.
- Read-back: CPU read of 0x0123 → `CPU_DI`=0x5A when `CPU_WAIT_N` rises. Then `VID_RD` at 0x0123 → `VID_D`=0x5A two edges later.
- Contention: `VID_RD`=1 for 10 cycles over a pending CPU read → CPU `RAM_A` is issued on the first cycle with `VID_RD`=0; wait extended by 10 cycles; every video byte is correct.
- Abort: pulse `CPU_CS` for 1 cycle only, write 0xA5 to 0x1FFF, `VID_RD`=1 for 4 cycles → write still lands at 0x1FFF; FSM returns to `IDLE`.
- `VRAM_SNOW_EN` defined: same contention stimulus with a write of 0x77 → write issued on the first `PEND` cycle; `VID_D`=0x77 for that slot; `CPU_WAIT_N` rises at 5 edges.
